// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: latches a binary value on start and
// produces packed BCD digits 2*IN_WIDTH+1 cycles later, holding the result between runs.

module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  // Nibbles reach at most 9 before adjustment, so +3 never leaves 4 bits
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module binary_to_bcd #(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS   = 4
) (
  input  logic                  clk_1Hz,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic [4*DIGITS-1:0]   bcdout,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + IN_WIDTH;
  localparam int CW = $clog2(IN_WIDTH+1);

  typedef enum logic [1:0] {IDLE, ADD3, SHIFT, DONE} state_t;

  state_t        state, state_n;
  logic [SW-1:0] sr, sr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcd_n;
  logic          busy_n, done_n;
  logic [BW-1:0] adj;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (sr[IN_WIDTH+4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      bcdout <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      bcdout <= bcd_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    bcd_n   = bcdout;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_n    = {{BW{1'b0}}, bin};
          cnt_n   = CW'(IN_WIDTH);
          busy_n  = 1'b1;
          state_n = ADD3;
        end
      end
      ADD3: begin
        sr_n    = {adj, sr[IN_WIDTH-1:0]};
        state_n = SHIFT;
      end
      SHIFT: begin
        sr_n    = sr << 1;
        cnt_n   = cnt - CW'(1);
        state_n = (cnt == CW'(1)) ? DONE : ADD3;
      end
      DONE: begin
        bcd_n   = sr[SW-1:IN_WIDTH];
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed checks of binary_to_bcd: reset, latency, digit boundaries,
// back-to-back restarts with start held high, and mid-run reset.

module tb_binary_to_bcd;
  logic        clk_1Hz;
  logic        rst;
  logic        start;
  logic [9:0]  bin;
  logic [15:0] bcdout;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int n;

  binary_to_bcd #(.IN_WIDTH(10), .DIGITS(4)) dut (
    .clk_1Hz (clk_1Hz),
    .rst     (rst),
    .start   (start),
    .bin     (bin),
    .bcdout  (bcdout),
    .busy    (busy),
    .done    (done)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Single pulsed conversion; bin is scrambled after acceptance to prove it is latched
  task automatic conv(input logic [9:0] v, input logic [15:0] exp, input string tag);
    logic [15:0] prev;
    prev  = bcdout;
    bin   = v;
    start = 1'b1;
    @(posedge clk_1Hz); #1;
    start = 1'b0;
    bin   = ~v;
    chk({tag, " busy@k"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_1Hz); #1;
      if (i == 10) chk({tag, " hold mid"}, 32'(bcdout), 32'(prev));
    end
    chk({tag, " busy@k+20"}, 32'(busy), 32'd1);
    chk({tag, " done@k+20"}, 32'(done), 32'd0);
    chk({tag, " hold@k+20"}, 32'(bcdout), 32'(prev));
    @(posedge clk_1Hz); #1;
    chk({tag, " done@k+21"}, 32'(done), 32'd1);
    chk({tag, " busy@k+21"}, 32'(busy), 32'd0);
    chk({tag, " bcd"}, 32'(bcdout), 32'(exp));
    @(posedge clk_1Hz); #1;
    chk({tag, " done@k+22"}, 32'(done), 32'd0);
    chk({tag, " bcd held"}, 32'(bcdout), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(posedge clk_1Hz);
    #1;
    chk("reset bcd",  32'(bcdout), 32'h0);
    chk("reset busy", 32'(busy),   32'd0);
    chk("reset done", 32'(done),   32'd0);
    @(negedge clk_1Hz) rst = 1'b0;
    @(posedge clk_1Hz); #1;

    conv(10'd0,    16'h0000, "zero");
    conv(10'd1023, 16'h1023, "full");
    conv(10'd999,  16'h0999, "999");
    conv(10'd512,  16'h0512, "512");
    conv(10'd5,    16'h0005, "5");

    // start held high: restart every 22 edges, bin change during busy ignored
    bin = 10'd100; start = 1'b1;
    @(posedge clk_1Hz); #1;
    bin = 10'd37;
    n = 0;
    do begin @(posedge clk_1Hz); #1; n++; end while (!done && n < 60);
    chk("held lat1", 32'(n), 32'd21);
    chk("held bcd1", 32'(bcdout), 32'h0100);
    n = 0;
    do begin @(posedge clk_1Hz); #1; n++; end while (!done && n < 60);
    start = 1'b0;
    chk("held lat2", 32'(n), 32'd22);
    chk("held bcd2", 32'(bcdout), 32'h0037);
    @(posedge clk_1Hz); #1;
    chk("held idle", 32'(busy), 32'd0);

    // async reset ten edges into a conversion of 750
    bin = 10'd750; start = 1'b1;
    @(posedge clk_1Hz); #1;
    start = 1'b0;
    repeat (10) @(posedge clk_1Hz);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst bcd",  32'(bcdout), 32'h0);
    chk("midrst busy", 32'(busy),   32'd0);
    chk("midrst done", 32'(done),   32'd0);
    @(negedge clk_1Hz) rst = 1'b0;
    @(posedge clk_1Hz); #1;
    chk("postrst busy", 32'(busy), 32'd0);
    conv(10'd750, 16'h0750, "750");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
